// File: rtl/write_back_cache.sv
// write_back_cache: direct-mapped write-back data cache in front of a BurstRAM controller.
// Define CACHE_STATS_EN to add stat_hits / stat_misses / stat_writebacks counters.
module write_back_cache #(
    parameter int DATA_BITWIDTH                        = 32,
    parameter int ADDRESS_BITWIDTH                     = 32,
    parameter int CACHE_LINE_IX_BITWIDTH               = 1,
    parameter int CACHE_IX_IN_LINE_BITWIDTH            = 3,
    parameter int CACHE_ADDRESS_LEADING_ZEROS_BITWIDTH = 2,
    parameter int RAM_DEPTH_BITWIDTH                   = 8,
    parameter int RAM_BURST_DATA_COUNT                 = 4,
    parameter int RAM_BURST_DATA_BITWIDTH              = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [DATA_BITWIDTH/8-1:0]           we,
    input  logic [ADDRESS_BITWIDTH-1:0]          addr,
    input  logic [DATA_BITWIDTH-1:0]             din,
    output logic [DATA_BITWIDTH-1:0]             dout,
    output logic                                 rdy,
    output logic                                 bsy,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                          stat_hits,
    output logic [31:0]                          stat_misses,
    output logic [31:0]                          stat_writebacks
`endif
);
    localparam int DW     = DATA_BITWIDTH;
    localparam int AW     = ADDRESS_BITWIDTH;
    localparam int NB     = DW / 8;
    localparam int LZ     = CACHE_ADDRESS_LEADING_ZEROS_BITWIDTH;
    localparam int WIX    = CACHE_IX_IN_LINE_BITWIDTH;
    localparam int LIX    = CACHE_LINE_IX_BITWIDTH;
    localparam int LINES  = 1 << LIX;
    localparam int LINE_W = DW << WIX;
    localparam int TAG_W  = AW - LZ - WIX - LIX;
    localparam int BW     = RAM_BURST_DATA_BITWIDTH;
    localparam int BEATS  = RAM_BURST_DATA_COUNT;
    localparam int BC_W   = $clog2(BEATS);
    localparam int BSHIFT = $clog2(BW / 8);
    localparam int RD     = RAM_DEPTH_BITWIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_WB_CMD, S_WB_DATA, S_FILL_CMD, S_FILL_WAIT, S_RESPOND
    } state_t;

    state_t              r_state, w_next;
    logic [LINES-1:0]    r_valid, r_dirty;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [LINE_W-1:0]   r_data [LINES];
    logic [AW-1:0]       r_addr;
    logic [NB-1:0]       r_we;
    logic [DW-1:0]       r_din, r_dout;
    logic [BC_W-1:0]     r_beat;
    logic                r_rdy;

    logic [WIX-1:0]      w_widx, q_widx;
    logic [LIX-1:0]      w_lidx, q_lidx;
    logic [TAG_W-1:0]    w_tag, q_tag;
    logic                w_idle, w_hit, w_vic_dirty, w_last;
    logic [DW-1:0]       w_hit_new, w_fill_new;
    logic [LINE_W-1:0]   w_fill_line, w_fill_final, w_vic_line;
    logic [AW-1:0]       w_vic_addr;
    logic                w_unused;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old,
                                              input logic [DW-1:0] d,
                                              input logic [NB-1:0] be);
        logic [DW-1:0] m;
        m = old;
        for (int b = 0; b < NB; b++)
            if (be[b]) m[8*b +: 8] = d[8*b +: 8];
        return m;
    endfunction

    // Burst start address: RAM-word address aligned to a whole burst.
    function automatic logic [RD-1:0] f_baddr(input logic [AW-1:0] a);
        return RD'(a >> BSHIFT) & ~RD'(BEATS - 1);
    endfunction

    assign w_widx      = addr[LZ +: WIX];
    assign w_lidx      = addr[LZ+WIX +: LIX];
    assign w_tag       = addr[AW-1 -: TAG_W];
    assign q_widx      = r_addr[LZ +: WIX];
    assign q_lidx      = r_addr[LZ+WIX +: LIX];
    assign q_tag       = r_addr[AW-1 -: TAG_W];
    assign w_idle      = (r_state == S_IDLE) || (r_state == S_RESPOND);
    assign w_hit       = r_valid[w_lidx] && (r_tag[w_lidx] == w_tag);
    assign w_vic_dirty = r_valid[w_lidx] && r_dirty[w_lidx];
    assign w_last      = (r_beat == BC_W'(BEATS - 1));
    assign w_hit_new   = f_merge(r_data[w_lidx][w_widx*DW +: DW], din, we);
    assign w_vic_line  = r_data[q_lidx];
    assign w_vic_addr  = {r_tag[q_lidx], q_lidx, {(WIX+LZ){1'b0}}};
    assign w_unused    = ^{addr[LZ-1:0], r_addr[LZ-1:0]};

    always_comb begin
        w_fill_line = r_data[q_lidx];
        w_fill_line[r_beat*BW +: BW] = br_rd_data;
        w_fill_new = f_merge(w_fill_line[q_widx*DW +: DW], r_din, r_we);
        w_fill_final = w_fill_line;
        w_fill_final[q_widx*DW +: DW] = w_fill_new;
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_RESPOND: begin
                w_next = S_IDLE;
                if (en && !w_hit)
                    w_next = w_vic_dirty ? S_WB_CMD : S_FILL_CMD;
            end
            S_WB_CMD:    if (!br_busy) w_next = S_WB_DATA;
            S_WB_DATA:   if (w_last) w_next = S_FILL_CMD;
            S_FILL_CMD:  if (!br_busy) w_next = S_FILL_WAIT;
            S_FILL_WAIT: if (br_rd_data_valid && w_last) w_next = S_RESPOND;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bsy        = !w_idle;
        br_cmd_en  = 1'b0;
        br_cmd     = 1'b0;
        br_addr    = '0;
        br_wr_data = '0;
        unique case (r_state)
            S_WB_CMD: begin
                br_cmd     = 1'b1;
                br_wr_data = w_vic_line[0 +: BW];
                if (!br_busy) begin
                    br_cmd_en = 1'b1;
                    br_addr   = f_baddr(w_vic_addr);
                end
            end
            S_WB_DATA: begin
                br_cmd     = 1'b1;
                br_wr_data = w_vic_line[r_beat*BW +: BW];
            end
            S_FILL_CMD: if (!br_busy) begin
                br_cmd_en = 1'b1;
                br_addr   = f_baddr(r_addr);
            end
            default: ;
        endcase
    end

    assign br_data_mask = '0;
    assign rdy          = r_rdy;
    assign dout         = r_dout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_rdy   <= 1'b0;
            r_dout  <= '0;
            r_beat  <= '0;
        end else begin
            r_rdy <= 1'b0;
            unique case (r_state)
                S_IDLE, S_RESPOND: if (en) begin
                    r_addr <= addr;
                    r_we   <= we;
                    r_din  <= din;
                    if (w_hit) begin
                        r_rdy  <= 1'b1;
                        r_dout <= w_hit_new;
                        if (|we) begin
                            r_data[w_lidx][w_widx*DW +: DW] <= w_hit_new;
                            r_dirty[w_lidx] <= 1'b1;
                        end
                    end
                end
                S_WB_CMD:   if (!br_busy) r_beat <= BC_W'(1);
                S_WB_DATA:  r_beat <= r_beat + 1'b1;
                S_FILL_CMD: if (!br_busy) r_beat <= '0;
                S_FILL_WAIT: if (br_rd_data_valid) begin
                    r_beat <= r_beat + 1'b1;
                    if (w_last) begin
                        // Install the line and complete the original access together.
                        r_data[q_lidx]  <= w_fill_final;
                        r_tag[q_lidx]   <= q_tag;
                        r_valid[q_lidx] <= 1'b1;
                        r_dirty[q_lidx] <= |r_we;
                        r_rdy           <= 1'b1;
                        r_dout          <= w_fill_new;
                    end else begin
                        r_data[q_lidx][r_beat*BW +: BW] <= br_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_hits       <= '0;
            stat_misses     <= '0;
            stat_writebacks <= '0;
        end else begin
            if (en && w_idle && w_hit)  stat_hits   <= stat_hits + 1'b1;
            if (en && w_idle && !w_hit) stat_misses <= stat_misses + 1'b1;
            if (br_cmd_en && br_cmd)    stat_writebacks <= stat_writebacks + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_write_back_cache.sv
// tb_write_back_cache: directed bench for write_back_cache with a BurstRAM model.
// Expected responses and burst commands are queued at stimulus time and checked on arrival.
module tb_write_back_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        rdy, bsy, br_cmd, br_cmd_en;
    logic [7:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data = '0;
    logic        br_rd_data_valid = 1'b0;
    logic        br_busy = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

    write_back_cache dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
        .dout(dout), .rdy(rdy), .bsy(bsy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses),
        .stat_writebacks(stat_writebacks)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int busy_viol = 0;
    logic [31:0] exp_q[$];
    logic [8:0]  exp_cmd_q[$];
    logic [8:0]  obs_cmd_q[$];

    // BurstRAM model: 4-beat bursts, two idle cycles before read data.
    logic [63:0] mem [256];
    logic [7:0]  wr_ptr, rd_ptr;
    int wr_left = 0, rd_left = 0, rd_wait = 0;

    always @(posedge clk) begin
        br_rd_data_valid <= 1'b0;
        if (!rst) begin
            br_busy <= 1'b0;
            wr_left = 0;
            rd_left = 0;
            rd_wait = 0;
        end else if (br_cmd_en) begin
            br_busy <= 1'b1;
            if (br_cmd) begin
                mem[br_addr] = br_wr_data;
                wr_ptr = br_addr + 8'd1;
                wr_left = 3;
            end else begin
                rd_ptr = br_addr;
                rd_left = 4;
                rd_wait = 2;
            end
        end else if (wr_left > 0) begin
            mem[wr_ptr] = br_wr_data;
            wr_ptr = wr_ptr + 8'd1;
            wr_left--;
            if (wr_left == 0) br_busy <= 1'b0;
        end else if (rd_left > 0) begin
            if (rd_wait > 0) rd_wait--;
            else begin
                br_rd_data <= mem[rd_ptr];
                br_rd_data_valid <= 1'b1;
                rd_ptr = rd_ptr + 8'd1;
                rd_left--;
                if (rd_left == 0) br_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (br_cmd_en) begin
            obs_cmd_q.push_back({br_cmd, br_addr});
            if (br_busy) busy_viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cmds(input string tag);
        chk({tag, "_ncmd"}, 64'(obs_cmd_q.size()), 64'(exp_cmd_q.size()));
        while (obs_cmd_q.size() > 0 && exp_cmd_q.size() > 0)
            chk({tag, "_cmd"}, 64'(obs_cmd_q.pop_front()), 64'(exp_cmd_q.pop_front()));
        obs_cmd_q.delete();
        exp_cmd_q.delete();
    endtask

    task automatic access(input string tag, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input bit hit, input bit clean);
        int lat;
        @(negedge clk);
        en = 1'b1; we = w; addr = a; din = d;
        exp_q.push_back(exp);
        @(negedge clk);
        en = 1'b0; we = '0;
        lat = 1;
        if (hit) chk({tag, "_lat1"}, 64'(rdy), 64'd1);
        else chk({tag, "_bsy"}, 64'(bsy), 64'd1);
        if (clean) chk({tag, "_cmd_t1"}, 64'(br_cmd_en), 64'd1);
        while (!rdy && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rdy"}, 64'(rdy), 64'd1);
        if (rdy) begin
            chk({tag, "_dout"}, 64'(dout), 64'(exp_q.pop_front()));
            chk({tag, "_bsy_rdy"}, 64'(bsy), 64'd0);
        end
        chk_cmds(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 64'h3F5A2E14_00000000;
        mem[8] = 64'h00000000_4E5F6A7B;

        repeat (3) @(negedge clk);
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_bsy", 64'(bsy), 64'd0);
        chk("rst_cmd_en", 64'(br_cmd_en), 64'd0);
        chk("rst_cmd", 64'(br_cmd), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_baddr", 64'(br_addr), 64'd0);
        chk("rst_wdata", br_wr_data, 64'd0);
        chk("rst_mask", 64'(br_data_mask), 64'd0);
        rst = 1'b1;

        exp_cmd_q.push_back({1'b0, 8'd0});
        access("rd4_miss", 4'h0, 32'd4, '0, 32'h3F5A2E14, 1'b0, 1'b1);
        access("rd4_hit", 4'h0, 32'd4, '0, 32'h3F5A2E14, 1'b1, 1'b0);
        access("wr8_full", 4'hF, 32'd8, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0);
        access("rd8_a", 4'h0, 32'd8, '0, 32'hDEADBEEF, 1'b1, 1'b0);
        access("wr8_byte1", 4'b0010, 32'd8, 32'h0000AB00, 32'hDEADABEF, 1'b1, 1'b0);
        access("rd8_b", 4'h0, 32'd8, '0, 32'hDEADABEF, 1'b1, 1'b0);

        exp_cmd_q.push_back({1'b1, 8'd0});
        exp_cmd_q.push_back({1'b0, 8'd8});
        access("rd64_dirty", 4'h0, 32'd64, '0, 32'h4E5F6A7B, 1'b0, 1'b0);
        chk("wb_beat1_lo", 64'(mem[1][31:0]), 64'hDEADABEF);
        chk("wb_beat0_hi", 64'(mem[0][63:32]), 64'h3F5A2E14);

        exp_cmd_q.push_back({1'b0, 8'd0});
        access("rd8_clean", 4'h0, 32'd8, '0, 32'hDEADABEF, 1'b0, 1'b1);
`ifdef CACHE_STATS_EN
        chk("stat_hits", 64'(stat_hits), 64'd5);
        chk("stat_misses", 64'(stat_misses), 64'd3);
        chk("stat_wbs", 64'(stat_writebacks), 64'd1);
`endif

        // Back-to-back hits, one per cycle.
        @(negedge clk);
        en = 1'b1; addr = 32'd8;
        @(negedge clk);
        chk("b2b_rdy0", 64'(rdy), 64'd1);
        chk("b2b_dout0", 64'(dout), 64'hDEADABEF);
        addr = 32'd4;
        @(negedge clk);
        en = 1'b0;
        chk("b2b_rdy1", 64'(rdy), 64'd1);
        chk("b2b_dout1", 64'(dout), 64'h3F5A2E14);

        // Reset while the fill is outstanding.
        @(negedge clk);
        en = 1'b1; addr = 32'd64;
        @(negedge clk);
        en = 1'b0;
        chk("rstm_cmd", 64'(br_cmd_en), 64'd1);
        @(negedge clk);
        chk("rstm_bsy_pre", 64'(bsy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstm_bsy", 64'(bsy), 64'd0);
        chk("rstm_rdy", 64'(rdy), 64'd0);
        chk("rstm_cmd_en", 64'(br_cmd_en), 64'd0);
        obs_cmd_q.delete();

        exp_cmd_q.push_back({1'b0, 8'd0});
        access("rd4_after_rst", 4'h0, 32'd4, '0, 32'h3F5A2E14, 1'b0, 1'b1);

        chk("cmd_en_vs_busy", 64'(busy_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
